// File: rtl/axis_burst_gate_pkg.sv
// Shared types and defaults for the burst gate and its TX skid stage.
package axis_burst_gate_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 256;
  localparam int DEFAULT_COUNT_WIDTH = 32;

  // Burst sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/axis_burst_gate_if.sv
// AXI-Stream channel bundle: master drives data/valid, slave drives ready.
interface axis_burst_gate_if
  import axis_burst_gate_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered output valid and registered input ready,
// so neither side sees a combinational path through this stage.
module axis_skid_buffer
  import axis_burst_gate_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  empty
);

  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  in_fire;
  logic                  load_out;

  // Ready only depends on the skid register, so it is a flop output.
  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && !skid_valid;
  // Output register may take a new beat when empty or being consumed.
  assign load_out = out_ready || !out_valid;
  assign empty    = !out_valid && !skid_valid;

  // Occupancy of output and skid registers.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid  <= in_fire;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
    end
  end

  // Payload path: output register refills from skid first, else from input.
  // NOTE: payload registers have no reset; the valid flags alone qualify them.
  always_ff @(posedge clk) begin
    if (load_out) begin
      out_data <= skid_valid ? skid_data : in_data;
    end
    if (!load_out && in_fire) begin
      skid_data <= in_data;
    end
  end

endmodule

// File: rtl/axis_burst_gate.sv
// Passes exactly BEAT_COUNT beats from RX to TX per START, then closes on a
// beat boundary once the registered TX stage has fully drained.
module axis_burst_gate
  import axis_burst_gate_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [COUNT_WIDTH-1:0] BEAT_COUNT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [COUNT_WIDTH-1:0] BEATS_SENT,
  axis_burst_gate_if.slave       AXIS_RX,
  axis_burst_gate_if.master      AXIS_TX
);

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   skid_ready;
  logic                   buf_empty;
  logic                   rx_fire;
  logic                   tx_fire;
  logic                   start_ok;

  assign start_ok       = (state == ST_IDLE) && START;
  assign AXIS_RX.tready = (state == ST_RUN) && !ABORT && (remaining != '0) && skid_ready;
  assign rx_fire        = AXIS_RX.tvalid && AXIS_RX.tready;
  assign tx_fire        = AXIS_TX.tvalid && AXIS_TX.tready;
  assign BUSY           = (state != ST_IDLE);

  axis_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_stage (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (AXIS_RX.tdata),
    .in_valid  (rx_fire),
    .in_ready  (skid_ready),
    .out_data  (AXIS_TX.tdata),
    .out_valid (AXIS_TX.tvalid),
    .out_ready (AXIS_TX.tready),
    .empty     (buf_empty)
  );

  // Next-state decode for the burst sequencer.
  // NOTE: state_next gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_next = (BEAT_COUNT != '0) ? ST_RUN : ST_FLUSH;
        end
      end
      ST_RUN: begin
        if (ABORT || (rx_fire && (remaining == COUNT_WIDTH'(1)))) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (buf_empty) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Beat counters and the completion pulse (raised as FLUSH returns to IDLE).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      remaining  <= '0;
      BEATS_SENT <= '0;
      DONE       <= 1'b0;
    end else begin
      DONE <= (state == ST_FLUSH) && buf_empty;
      if (start_ok) begin
        remaining  <= BEAT_COUNT;
        BEATS_SENT <= '0;
      end else begin
        if (rx_fire) begin
          remaining <= remaining - COUNT_WIDTH'(1);
        end
        if (tx_fire) begin
          BEATS_SENT <= BEATS_SENT + COUNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_burst_gate.sv
// Directed bench for axis_burst_gate: inputs change on the falling edge,
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_axis_burst_gate;

  localparam int DW = 256;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          START;
  logic          ABORT;
  logic [CW-1:0] BEAT_COUNT;
  logic          BUSY;
  logic          DONE;
  logic [CW-1:0] BEATS_SENT;

  axis_burst_gate_if #(.DATA_WIDTH(DW)) rx_if ();
  axis_burst_gate_if #(.DATA_WIDTH(DW)) tx_if ();

  axis_burst_gate #(
    .DATA_WIDTH  (DW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .START      (START),
    .ABORT      (ABORT),
    .BEAT_COUNT (BEAT_COUNT),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .BEATS_SENT (BEATS_SENT),
    .AXIS_RX    (rx_if.slave),
    .AXIS_TX    (tx_if.master)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Observations of the most recent burst.
  logic [DW-1:0] tx_q[$];
  int            tx_k[$];
  int            rx_k[$];
  int            done_k[$];
  int            busy_cnt;
  int            rx_hi_cnt;
  int            rx_bad;
  int            stab_err;
  logic [DW-1:0] src;
  logic [DW-1:0] src_base;

  // Scenario knobs.
  int   rdy_on_k;
  int   rdy_len;
  logic rdy_pat [8];
  int   abort_after;
  int   restart_k;
  int   stop_tx;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_defaults();
    rdy_on_k    = 0;
    rdy_len     = 0;
    abort_after = -1;
    restart_k   = -1;
    stop_tx     = 0;
  endtask

  // Drive one burst from a free-running source; sample k is taken before rising edge k.
  task automatic run_burst(input logic [CW-1:0] cnt, input int max_k);
    int            rx_cnt;
    int            abort_k;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          rx_hs;
    logic          tx_hs;
    tx_q.delete(); tx_k.delete(); rx_k.delete(); done_k.delete();
    busy_cnt = 0; rx_hi_cnt = 0; rx_bad = 0; stab_err = 0;
    rx_cnt = 0; abort_k = -1; prev_stall = 1'b0; prev_data = '0;
    src_base = src;
    for (int k = 0; k < max_k; k++) begin
      START      = (k == 0) || (k == restart_k);
      BEAT_COUNT = (k == 0) ? cnt : cnt + 32'd7;
      ABORT      = (abort_after >= 0) && (abort_k < 0) && (rx_cnt == abort_after);
      if (ABORT) abort_k = k;
      rx_if.tvalid = 1'b1;
      rx_if.tdata  = src;
      if (k < rdy_on_k)  tx_if.tready = 1'b0;
      else if (rdy_len == 0) tx_if.tready = 1'b1;
      else tx_if.tready = rdy_pat[k % rdy_len];
      #1;
      rx_hs = rx_if.tvalid && rx_if.tready;
      tx_hs = tx_if.tvalid && tx_if.tready;
      if (rx_if.tready) begin
        rx_hi_cnt++;
        if ((rx_cnt >= int'(cnt)) || (abort_k >= 0)) rx_bad++;
      end
      if (rx_hs) begin
        rx_k.push_back(k);
        rx_cnt++;
      end
      if (tx_hs) begin
        tx_q.push_back(tx_if.tdata);
        tx_k.push_back(k);
      end
      if (DONE) done_k.push_back(k);
      if (BUSY) busy_cnt++;
      if (prev_stall && (!tx_if.tvalid || (tx_if.tdata !== prev_data))) stab_err++;
      prev_stall = tx_if.tvalid && !tx_if.tready;
      prev_data  = tx_if.tdata;
      cycle();
      if (rx_hs) src = src + 1'b1;
      if ((stop_tx > 0) && (tx_q.size() >= stop_tx)) break;
    end
    START = 1'b0;
    ABORT = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; START = 1'b0; ABORT = 1'b0; BEAT_COUNT = '0;
    rx_if.tvalid = 1'b1; rx_if.tdata = '0; tx_if.tready = 1'b1;
    src = 256'd1;
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", DONE); end
    tests_run++; if (BEATS_SENT !== 32'd0) begin tests_failed++; $display("FAIL reset_beats: got %0d want 0", BEATS_SENT); end
    tests_run++; if (tx_if.tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b want 0", tx_if.tvalid); end
    tests_run++; if (rx_if.tready !== 1'b0) begin tests_failed++; $display("FAIL reset_rready: got %b want 0", rx_if.tready); end
    @(negedge clk);
    resetn = 1'b1;
    cycle(); cycle();
    #1;
    tests_run++; if ((BUSY !== 1'b0) || (rx_if.tready !== 1'b0)) begin tests_failed++; $display("FAIL idle_after_reset: busy %b rready %b want 0 0", BUSY, rx_if.tready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_defaults();
    run_burst(32'd4, 12);
    tests_run++; if (rx_k.size() != 4) begin tests_failed++; $display("FAIL basic_rx_count: got %0d want 4", rx_k.size()); end
    tests_run++; if (tx_q.size() != 4) begin tests_failed++; $display("FAIL basic_tx_count: got %0d want 4", tx_q.size()); end
    for (int i = 0; i < tx_q.size(); i++) begin
      tests_run++; if (tx_q[i] !== src_base + 256'(i)) begin tests_failed++; $display("FAIL basic_tx_data[%0d]: got %0h want %0h", i, tx_q[i], src_base + 256'(i)); end
      tests_run++; if (tx_k[i] != 2 + i) begin tests_failed++; $display("FAIL basic_tx_cycle[%0d]: got %0d want %0d", i, tx_k[i], 2 + i); end
    end
    if (rx_k.size() > 0) begin
      tests_run++; if (rx_k[0] != 1) begin tests_failed++; $display("FAIL basic_first_rx: got %0d want 1", rx_k[0]); end
    end
    tests_run++; if (rx_bad != 0) begin tests_failed++; $display("FAIL basic_rready_after_last: got %0d want 0", rx_bad); end
    tests_run++; if ((done_k.size() != 1) || (done_k[0] != 7)) begin tests_failed++; $display("FAIL basic_done: pulses %0d want 1 at cycle 7", done_k.size()); end
    tests_run++; if (busy_cnt != 6) begin tests_failed++; $display("FAIL basic_busy_len: got %0d want 6", busy_cnt); end
    tests_run++; if (BEATS_SENT !== 32'd4) begin tests_failed++; $display("FAIL basic_beats_sent: got %0d want 4", BEATS_SENT); end
  endtask

  task automatic test_backpressure();
    set_defaults();
    rdy_len = 8;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    run_burst(32'd8, 60);
    tests_run++; if (tx_q.size() != 8) begin tests_failed++; $display("FAIL bp_tx_count: got %0d want 8", tx_q.size()); end
    for (int i = 0; i < tx_q.size(); i++) begin
      tests_run++; if (tx_q[i] !== src_base + 256'(i)) begin tests_failed++; $display("FAIL bp_tx_data[%0d]: got %0h want %0h", i, tx_q[i], src_base + 256'(i)); end
    end
    tests_run++; if (rx_k.size() != 8) begin tests_failed++; $display("FAIL bp_rx_count: got %0d want 8", rx_k.size()); end
    tests_run++; if (stab_err != 0) begin tests_failed++; $display("FAIL bp_stall_stability: got %0d want 0", stab_err); end
    tests_run++; if (rx_bad != 0) begin tests_failed++; $display("FAIL bp_rready_after_last: got %0d want 0", rx_bad); end
    tests_run++; if (done_k.size() != 1) begin tests_failed++; $display("FAIL bp_done_pulses: got %0d want 1", done_k.size()); end
    tests_run++; if (BEATS_SENT !== 32'd8) begin tests_failed++; $display("FAIL bp_beats_sent: got %0d want 8", BEATS_SENT); end
  endtask

  task automatic test_zero_count();
    set_defaults();
    run_burst(32'd0, 8);
    tests_run++; if (rx_hi_cnt != 0) begin tests_failed++; $display("FAIL zero_rready: got %0d cycles high want 0", rx_hi_cnt); end
    tests_run++; if ((done_k.size() != 1) || (done_k[0] != 2)) begin tests_failed++; $display("FAIL zero_done: pulses %0d want 1 at cycle 2", done_k.size()); end
    tests_run++; if (busy_cnt != 1) begin tests_failed++; $display("FAIL zero_busy_len: got %0d want 1", busy_cnt); end
    tests_run++; if (tx_q.size() != 0) begin tests_failed++; $display("FAIL zero_tx_count: got %0d want 0", tx_q.size()); end
    tests_run++; if (BEATS_SENT !== 32'd0) begin tests_failed++; $display("FAIL zero_beats_sent: got %0d want 0", BEATS_SENT); end
  endtask

  task automatic test_abort();
    set_defaults();
    rdy_on_k    = 6;
    abort_after = 2;
    restart_k   = 4;
    run_burst(32'd10, 20);
    tests_run++; if (rx_k.size() != 2) begin tests_failed++; $display("FAIL abort_rx_count: got %0d want 2", rx_k.size()); end
    tests_run++; if (rx_bad != 0) begin tests_failed++; $display("FAIL abort_rready_after: got %0d want 0", rx_bad); end
    tests_run++; if (tx_q.size() != 2) begin tests_failed++; $display("FAIL abort_tx_count: got %0d want 2", tx_q.size()); end
    for (int i = 0; i < tx_q.size(); i++) begin
      tests_run++; if (tx_q[i] !== src_base + 256'(i)) begin tests_failed++; $display("FAIL abort_tx_data[%0d]: got %0h want %0h", i, tx_q[i], src_base + 256'(i)); end
    end
    tests_run++; if ((done_k.size() != 1) || (done_k[0] != 9)) begin tests_failed++; $display("FAIL abort_done: pulses %0d want 1 at cycle 9", done_k.size()); end
    tests_run++; if (BEATS_SENT !== 32'd2) begin tests_failed++; $display("FAIL abort_beats_sent: got %0d want 2", BEATS_SENT); end
  endtask

  task automatic test_reset_mid_burst();
    set_defaults();
    stop_tx = 5;
    run_burst(32'd16, 40);
    #1;
    tests_run++; if (BEATS_SENT !== 32'd5) begin tests_failed++; $display("FAIL mid_beats_before: got %0d want 5", BEATS_SENT); end
    tests_run++; if ((BUSY !== 1'b1) || (done_k.size() != 0)) begin tests_failed++; $display("FAIL mid_state_before: busy %b done pulses %0d want 1 0", BUSY, done_k.size()); end
    #1 resetn = 1'b0;
    #1;
    tests_run++; if (tx_if.tvalid !== 1'b0) begin tests_failed++; $display("FAIL mid_async_tvalid: got %b want 0", tx_if.tvalid); end
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL mid_async_busy: got %b want 0", BUSY); end
    tests_run++; if (BEATS_SENT !== 32'd0) begin tests_failed++; $display("FAIL mid_async_beats: got %0d want 0", BEATS_SENT); end
    tests_run++; if (rx_if.tready !== 1'b0) begin tests_failed++; $display("FAIL mid_async_rready: got %b want 0", rx_if.tready); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cycle();
    #1;
    tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL mid_no_done: got %b want 0", DONE); end
    @(negedge clk);
    set_defaults();
    run_burst(32'd3, 15);
    tests_run++; if (tx_q.size() != 3) begin tests_failed++; $display("FAIL mid_fresh_count: got %0d want 3", tx_q.size()); end
    for (int i = 0; i < tx_q.size(); i++) begin
      tests_run++; if (tx_q[i] !== src_base + 256'(i)) begin tests_failed++; $display("FAIL mid_fresh_data[%0d]: got %0h want %0h", i, tx_q[i], src_base + 256'(i)); end
    end
    tests_run++; if (done_k.size() != 1) begin tests_failed++; $display("FAIL mid_fresh_done: got %0d pulses want 1", done_k.size()); end
    tests_run++; if (BEATS_SENT !== 32'd3) begin tests_failed++; $display("FAIL mid_fresh_beats: got %0d want 3", BEATS_SENT); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_abort();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case a scenario loop never returns.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
